// File: rtl/ad7606_pkg.sv
// Shared constants, FSM encoding and conversion-length helper for the AD7606 responder model.
package ad7606_pkg;

  localparam int N_CH   = 8;
  localparam int WORD_W = 16;
  localparam int PTR_W  = 3;

  localparam logic [2:0] OS_INVALID = 3'd7;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_DELAY,
    ST_CONV
  } state_t;

  typedef logic [WORD_W-1:0] word_t;

  // BUSY length grows with the oversampling ratio; the reserved code falls back to no oversampling.
  function automatic int conv_len(input int base, input logic [2:0] os);
    return (os == OS_INVALID) ? base : (base << os);
  endfunction

endpackage

// File: rtl/ad7606_emu_sync.sv
// Two-flop synchronizer for one asynchronous control pin, with rise/fall pulses on the synced copy.
module ad7606_emu_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_d;

  // NOTE: every flop here uses <= so all three stages sample the old value on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      q_d  <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/ad7606_emulator.sv
// AD7606 parallel-mode responder: BUSY timing, channel snapshot and RD#-strobed readback.
// Define AD7606_EMU_PATTERN_EN to replace ch_data with a {channel, conv_count} ramp.
module ad7606_emulator
  import ad7606_pkg::*;
#(
  parameter int CONV_CYCLES = 200,
  parameter int BUSY_DELAY  = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     convst,
  input  logic                     cs_n,
  input  logic                     rd_n,
  input  logic                     adc_reset,
  input  logic                     stby_n,
  input  logic [2:0]               os,
  input  logic [N_CH*WORD_W-1:0]   ch_data,
  output logic                     busy,
  output logic                     first_data,
  output logic [WORD_W-1:0]        db,
  output logic                     db_oe,
  output logic                     overrun,
  output logic [15:0]              conv_count
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(BUSY_DELAY - 1);

  logic convst_s, convst_rise, convst_fall;
  logic cs_n_s, cs_n_rise, cs_n_fall;
  logic rd_n_s, rd_n_rise, rd_fall;
  logic adc_reset_s, adc_reset_rise, adc_reset_fall;
  logic stby_n_s, stby_n_rise, stby_n_fall;

  ad7606_emu_sync #(.RST_VAL(1'b0)) u_sync_convst (
    .clk(clk), .rst(rst), .d(convst),
    .q(convst_s), .rise(convst_rise), .fall(convst_fall)
  );

  ad7606_emu_sync #(.RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst(rst), .d(cs_n),
    .q(cs_n_s), .rise(cs_n_rise), .fall(cs_n_fall)
  );

  ad7606_emu_sync #(.RST_VAL(1'b1)) u_sync_rd_n (
    .clk(clk), .rst(rst), .d(rd_n),
    .q(rd_n_s), .rise(rd_n_rise), .fall(rd_fall)
  );

  ad7606_emu_sync #(.RST_VAL(1'b0)) u_sync_adc_reset (
    .clk(clk), .rst(rst), .d(adc_reset),
    .q(adc_reset_s), .rise(adc_reset_rise), .fall(adc_reset_fall)
  );

  ad7606_emu_sync #(.RST_VAL(1'b1)) u_sync_stby_n (
    .clk(clk), .rst(rst), .d(stby_n),
    .q(stby_n_s), .rise(stby_n_rise), .fall(stby_n_fall)
  );

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] t_last;
  logic [CNT_W-1:0] conv_last;
  logic [PTR_W-1:0] rd_ptr;
  word_t            shadow [N_CH];
  word_t            result [N_CH];
  word_t            snap   [N_CH];
  logic             start_req;

  assign conv_last = CNT_W'(conv_len(CONV_CYCLES, os) - 1);
  assign start_req = convst_rise & stby_n_s;

  // NOTE: every element gets a value before any branch, so this block cannot infer a latch.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
`ifdef AD7606_EMU_PATTERN_EN
      snap[k] = {3'(k), conv_count[12:0]};
`else
      snap[k] = ch_data[k*WORD_W +: WORD_W];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RESET;
      timer      <= '0;
      t_last     <= '0;
      busy       <= 1'b0;
      first_data <= 1'b0;
      db         <= '0;
      overrun    <= 1'b0;
      conv_count <= '0;
      rd_ptr     <= '0;
      // NOTE: both banks are cleared so a read before the first conversion returns zero.
      for (int k = 0; k < N_CH; k++) begin
        shadow[k] <= '0;
        result[k] <= '0;
      end
    end else begin
      // Read uses the bank and pointer as they stood before this edge; later writes to rd_ptr win.
      if (rd_fall && !cs_n_s) begin
        db         <= result[rd_ptr];
        first_data <= (rd_ptr == '0);
        rd_ptr     <= rd_ptr + 1'b1;
      end

      if (adc_reset_s) begin
        state   <= ST_RESET;
        timer   <= '0;
        busy    <= 1'b0;
        overrun <= 1'b0;
        rd_ptr  <= '0;
        for (int k = 0; k < N_CH; k++) begin
          result[k] <= '0;
        end
      end else begin
        case (state)
          ST_RESET: state <= ST_IDLE;

          ST_IDLE: begin
            if (start_req) begin
              state <= ST_DELAY;
              timer <= '0;
            end
          end

          ST_DELAY: begin
            if (start_req) begin
              overrun <= 1'b1;
            end
            if (timer == DELAY_LAST) begin
              state  <= ST_CONV;
              timer  <= '0;
              busy   <= 1'b1;
              t_last <= conv_last;
              for (int k = 0; k < N_CH; k++) begin
                shadow[k] <= snap[k];
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end

          ST_CONV: begin
            if (start_req) begin
              overrun <= 1'b1;
            end
            if (timer == t_last) begin
              state      <= ST_IDLE;
              timer      <= '0;
              busy       <= 1'b0;
              rd_ptr     <= '0;
              conv_count <= conv_count + 1'b1;
              for (int k = 0; k < N_CH; k++) begin
                result[k] <= shadow[k];
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end

          default: state <= ST_RESET;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_oe <= 1'b0;
    end else begin
      db_oe <= ~cs_n_s & ~rd_n_s;
    end
  end

  // Edge pulses and levels this block has no use for.
  logic unused_sync;
`ifdef AD7606_EMU_PATTERN_EN
  assign unused_sync = ^{convst_s, convst_fall, cs_n_rise, cs_n_fall, rd_n_rise,
                         adc_reset_rise, adc_reset_fall, stby_n_rise, stby_n_fall, ch_data};
`else
  assign unused_sync = ^{convst_s, convst_fall, cs_n_rise, cs_n_fall, rd_n_rise,
                         adc_reset_rise, adc_reset_fall, stby_n_rise, stby_n_fall};
`endif

endmodule

// File: tb/tb_ad7606_emulator.sv
// Self-checking bench for ad7606_emulator: randomized channel data against a bank/pointer model.
`timescale 1ns/1ps
module tb_ad7606_emulator;

  localparam int CONV = 200;

`ifdef AD7606_EMU_PATTERN_EN
  localparam bit PATTERN = 1'b1;
`else
  localparam bit PATTERN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         convst = 1'b0;
  logic         cs_n = 1'b1;
  logic         rd_n = 1'b1;
  logic         adc_reset = 1'b0;
  logic         stby_n = 1'b1;
  logic [2:0]   os = 3'd0;
  logic [127:0] ch_data = '0;
  logic         busy;
  logic         first_data;
  logic [15:0]  db;
  logic         db_oe;
  logic         overrun;
  logic [15:0]  conv_count;

  ad7606_emulator #(
    .CONV_CYCLES(CONV),
    .BUSY_DELAY (2),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .convst    (convst),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .adc_reset (adc_reset),
    .stby_n    (stby_n),
    .os        (os),
    .ch_data   (ch_data),
    .busy      (busy),
    .first_data(first_data),
    .db        (db),
    .db_oe     (db_oe),
    .overrun   (overrun),
    .conv_count(conv_count)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the controller should read back, and in which order.
  logic [15:0] m_bank [8];
  logic [15:0] m_next [8];
  int          m_ptr   = 0;
  logic [15:0] m_count = '0;

  // Independent BUSY pulse-width monitor.
  int   run_len    = 0;
  int   last_width = 0;
  int   busy_rises = 0;
  logic busy_q     = 1'b0;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!busy_q) busy_rises++;
      run_len++;
    end else if (busy_q) begin
      last_width = run_len;
      run_len    = 0;
    end
    busy_q = (busy === 1'b1);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] snap_word(input int k, input logic [127:0] d, input logic [12:0] cnt);
    logic [2:0] kk;
    kk = 3'(k);
    return PATTERN ? {kk, cnt} : d[k*16 +: 16];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'(level));
  endtask

  task automatic pulse_convst();
    @(negedge clk);
    convst = 1'b1;
    repeat (3) @(negedge clk);
    convst = 1'b0;
  endtask

  task automatic start_conv(input logic [2:0] os_v);
    os = os_v;
    pulse_convst();
    wait_busy(1'b1, 20, "busy_rise");
    for (int k = 0; k < 8; k++) m_next[k] = snap_word(k, ch_data, m_count[12:0]);
  endtask

  task automatic finish_conv(input logic [2:0] os_v);
    int exp_w;
    exp_w = (os_v == 3'd7) ? CONV : (CONV << os_v);
    wait_busy(1'b0, exp_w + 20, "busy_fall");
    @(negedge clk);
    check("busy_width", 32'(last_width), 32'(exp_w));
    m_count++;
    for (int k = 0; k < 8; k++) m_bank[k] = m_next[k];
    m_ptr = 0;
    check("conv_count", 32'(conv_count), 32'(m_count));
  endtask

  task automatic convert(input logic [2:0] os_v);
    start_conv(os_v);
    finish_conv(os_v);
  endtask

  task automatic do_read(input string tag);
    cs_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b0;
    repeat (4) @(negedge clk);
    check(tag, 32'(db), 32'(m_bank[m_ptr]));
    check("first_data", 32'(first_data), 32'(m_ptr == 0));
    check("db_oe_on", 32'(db_oe), 32'd1);
    m_ptr = (m_ptr + 1) % 8;
    rd_n = 1'b1;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic randomize_data();
    for (int k = 0; k < 4; k++) ch_data[k*32 +: 32] = $urandom;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_bank[k] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_first_data", 32'(first_data), 32'd0);
    check("rst_db",         32'(db),         32'd0);
    check("rst_db_oe",      32'(db_oe),      32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_conv_count", 32'(conv_count), 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // Directed ramp 0x1111..0x8888, os=0
    for (int k = 0; k < 8; k++) ch_data[k*16 +: 16] = 16'(16'h1111 * (k + 1));
    convert(3'd0);
    for (int r = 0; r < 8; r++) do_read("read_ramp");
    check("db_oe_off", 32'(db_oe), 32'd0);
    repeat (10) @(negedge clk);
    check("db_hold", 32'(db), 32'(m_bank[7]));

    // Oversampling lengths, including the invalid code, with random data
    randomize_data();
    convert(3'd3);
    for (int r = 0; r < 8; r++) do_read("read_os3");
    randomize_data();
    convert(3'd7);
    for (int r = 0; r < 8; r++) do_read("read_os7");
    randomize_data();
    begin
      logic [2:0] os_r;
      os_r = 3'($urandom_range(5, 0));
      convert(os_r);
    end
    for (int r = 0; r < 8; r++) do_read("read_os_rand");

    // Standby: CONVST ignored without flagging overrun
    begin
      int rises_before;
      stby_n = 1'b0;
      repeat (4) @(negedge clk);
      rises_before = busy_rises;
      pulse_convst();
      repeat (300) @(negedge clk);
      check("stby_no_busy", 32'(busy_rises - rises_before), 32'd0);
      check("stby_no_overrun", 32'(overrun), 32'd0);
      stby_n = 1'b1;
      repeat (4) @(negedge clk);
    end

    // Overrun: second CONVST 50 clk into CONV; reads meanwhile see the previous bank
    randomize_data();
    start_conv(3'd0);
    repeat (50) @(negedge clk);
    pulse_convst();
    randomize_data();
    do_read("read_during_conv");
    do_read("read_during_conv");
    finish_conv(3'd0);
    check("overrun_set", 32'(overrun), 32'd1);
    for (int r = 0; r < 8; r++) do_read("read_after_overrun");

    // Ten strobes wrap the pointer back to ch1
    randomize_data();
    convert(3'd0);
    for (int r = 0; r < 10; r++) do_read("read_wrap");

    // adc_reset mid-conversion
    randomize_data();
    start_conv(3'd1);
    repeat (30) @(negedge clk);
    adc_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("adc_reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("adc_reset_overrun", 32'(overrun), 32'd0);
    adc_reset = 1'b0;
    for (int k = 0; k < 8; k++) m_bank[k] = '0;
    m_ptr = 0;
    repeat (6) @(negedge clk);
    check("adc_reset_count_kept", 32'(conv_count), 32'(m_count));
    for (int r = 0; r < 8; r++) do_read("read_after_reset");
    randomize_data();
    convert(3'd0);
    for (int r = 0; r < 8; r++) do_read("read_recovered");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
